// File: rtl/cla_pipelined_addsub_pkg.sv
// Shared defaults, 4-bit CLA group primitive and the width/segment consistency check
// used by the pipelined adder/subtractor and its segment logic.
package cla_pipelined_addsub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG_W = 8;
  localparam int DEF_SEGS  = DEF_WIDTH / DEF_SEG_W;
  localparam int GRP_W     = 4;

  typedef struct packed {
    logic [GRP_W-1:0] sum;
    logic             p;
    logic             g;
  } cla4_t;

  function automatic bit cfg_ok(input int width, input int seg_w, input int segs);
    return (width == segs * seg_w) && (seg_w % GRP_W == 0) && (segs > 0);
  endfunction

  // Two-level look-ahead inside one 4-bit group; no internal ripple.
  function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] pv;
    logic [3:0] gv;
    logic [3:0] c;
    cla4_t      r;
    pv   = a ^ b;
    gv   = a & b;
    c[0] = c0;
    c[1] = gv[0] | (pv[0] & c0);
    c[2] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & c0);
    c[3] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0]) | (pv[2] & pv[1] & pv[0] & c0);
    r.sum = pv ^ c;
    r.p   = &pv;
    r.g   = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1]) | (pv[3] & pv[2] & pv[1] & gv[0]);
    return r;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit CLA built from 4-bit groups and a group-level carry unit;
// zero latency, no handshake (pure logic inside one pipeline stage).
module cla_segment
  import cla_pipelined_addsub_pkg::*;
#(
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             cmsb,
  output logic             p,
  output logic             g
);

  localparam int NG = SEG_W / GRP_W;

  logic [NG:0] gc;

  always_comb begin
    cla4_t grp;
    grp   = '0;
    gc    = '0;
    gc[0] = cin;
    sum   = '0;
    p     = 1'b1;
    g     = 1'b0;
    for (int j = 0; j < NG; j++) begin
      grp                 = cla4(a[j*GRP_W +: GRP_W], b[j*GRP_W +: GRP_W], gc[j]);
      sum[j*GRP_W +: GRP_W] = grp.sum;
      gc[j+1]             = grp.g | (grp.p & gc[j]);
      p                   = p & grp.p;
      g                   = grp.g | (grp.p & g);
    end
  end

  assign cout = gc[NG];
  // Carry into the top bit recovered from that bit's sum and operands.
  assign cmsb = sum[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];

endmodule

// File: rtl/cla_pipelined_addsub.sv
// Pipelined CLA add/sub: one segment per stage, latency SEGS cycles, one op/cycle.
// Whole pipe stalls (bubbles kept) when the output is held; in_ready = !out_valid | out_ready.
module cla_pipelined_addsub
  import cla_pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W,
  parameter int SEGS  = DEF_SEGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             P,
  output logic             G
);

  if (!cfg_ok(WIDTH, SEG_W, SEGS)) begin : g_bad_params
    $error("cla_pipelined_addsub: WIDTH must equal SEGS*SEG_W and SEG_W must be a multiple of 4");
  end

  logic            advance;
  logic [SEGS-1:0] vld;

  assign out_valid = vld[SEGS-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (advance) begin
      vld <= (vld << 1) | SEGS'(in_valid);
    end
  end

  for (genvar k = 0; k < SEGS; k++) begin : g_stage
    localparam int RIN  = WIDTH - k * SEG_W;
    localparam int SACC = (k + 1) * SEG_W;

    logic [RIN-1:0]   a_in;
    logic [RIN-1:0]   b_in;
    logic             c_in;
    logic             p_in;
    logic             g_in;
    logic             v_in;
    logic [SEG_W-1:0] s_seg;
    logic             c_seg;
    logic             cm_seg;
    logic             p_seg;
    logic             g_seg;
    logic [SACC-1:0]  sum_nxt;
    logic [SACC-1:0]  sum_q;
    logic             c_q;
    logic             p_q;
    logic             g_q;
    logic             load;

    if (k == 0) begin : g_head
      assign a_in    = in1;
      assign b_in    = sub ? ~in2 : in2;
      assign c_in    = cin ^ sub;
      assign p_in    = 1'b1;
      assign g_in    = 1'b0;
      assign v_in    = in_valid;
      assign sum_nxt = s_seg;
    end else begin : g_body
      assign a_in    = g_stage[k-1].g_fwd.a_q;
      assign b_in    = g_stage[k-1].g_fwd.b_q;
      assign c_in    = g_stage[k-1].c_q;
      assign p_in    = g_stage[k-1].p_q;
      assign g_in    = g_stage[k-1].g_q;
      assign v_in    = vld[k-1];
      assign sum_nxt = {s_seg, g_stage[k-1].sum_q};
    end

    // Data regs only move with a real op so outputs keep their last value across bubbles.
    assign load = advance && v_in;

    cla_segment #(.SEG_W(SEG_W)) u_seg (
      .a    (a_in[SEG_W-1:0]),
      .b    (b_in[SEG_W-1:0]),
      .cin  (c_in),
      .sum  (s_seg),
      .cout (c_seg),
      .cmsb (cm_seg),
      .p    (p_seg),
      .g    (g_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        p_q   <= 1'b0;
        g_q   <= 1'b0;
      end else if (load) begin
        sum_q <= sum_nxt;
        c_q   <= c_seg;
        p_q   <= p_seg & p_in;
        g_q   <= g_seg | (p_seg & g_in);
      end
    end

    if (k < SEGS - 1) begin : g_fwd
      logic [RIN-SEG_W-1:0] a_q;
      logic [RIN-SEG_W-1:0] b_q;
      logic                 cm_unused;

      assign cm_unused = cm_seg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_in[RIN-1:SEG_W];
          b_q <= b_in[RIN-1:SEG_W];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= cm_seg ^ c_seg;
        end
      end
    end
  end

  assign out  = g_stage[SEGS-1].sum_q;
  assign cout = g_stage[SEGS-1].c_q;
  assign ovf  = g_stage[SEGS-1].g_last.ovf_q;
  assign P    = g_stage[SEGS-1].p_q;
  assign G    = g_stage[SEGS-1].g_q;

endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Bench for cla_pipelined_addsub: arithmetic reference model plus directed literal vectors,
// at the default 32-bit configuration and a 64-bit/16-bit-segment configuration.
module tb_cla_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic        out_valid, out_ready = 1'b1, cout, ovf, p_o, g_o;
  logic [31:0] in1 = '0, in2 = '0, out;

  logic        in_valid64 = 1'b0, in_ready64, cin64 = 1'b0, sub64 = 1'b0;
  logic        out_valid64, out_ready64 = 1'b1, cout64, ovf64, p64, g64;
  logic [63:0] a64 = '0, b64 = '0, out64;

  typedef struct packed {
    logic [63:0] out;
    logic        cout;
    logic        ovf;
    logic        p;
    logic        g;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out32  = 0;
  int   n_out64  = 0;

  always #5 clk = ~clk;

  cla_pipelined_addsub dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .cout(cout), .ovf(ovf), .P(p_o), .G(g_o)
  );

  cla_pipelined_addsub #(.WIDTH(64), .SEG_W(16), .SEGS(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .in1(a64), .in2(b64),
    .cin(cin64), .sub(sub64), .out_valid(out_valid64), .out_ready(out_ready64), .out(out64),
    .cout(cout64), .ovf(ovf64), .P(p64), .G(g64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Plain w-bit modular arithmetic: out = A + B' + c0, with flags from wider sums.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic s);
    logic [64:0] mask, msk1, aa, bp, c0, full, low, gen;
    exp_t        e;
    mask   = (65'd1 << w) - 65'd1;
    msk1   = (65'd1 << (w - 1)) - 65'd1;
    aa     = {1'b0, a} & mask;
    bp     = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
    c0     = {64'd0, ci ^ s};
    full   = aa + bp + c0;
    low    = (aa & msk1) + (bp & msk1) + c0;
    gen    = aa + bp;
    e.out  = full[63:0] & mask[63:0];
    e.cout = full[w];
    e.ovf  = low[w-1] ^ full[w];
    e.p    = ((aa ^ bp) == mask);
    e.g    = gen[w];
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q32.delete();
      q64.delete();
    end else begin
      chk("in_ready32", in_ready, !out_valid || out_ready);
      if (in_valid && in_ready) q32.push_back(model(32, {32'd0, in1}, {32'd0, in2}, cin, sub));
      if (out_valid) begin
        if (q32.size() == 0) chk("out32_unexpected", out_valid, 1'b0);
        else begin
          e = q32[0];
          chk("out32", {32'd0, out}, e.out);
          chk("cout32", cout, e.cout);
          chk("ovf32", ovf, e.ovf);
          chk("P32", p_o, e.p);
          chk("G32", g_o, e.g);
          if (out_ready) begin
            void'(q32.pop_front());
            n_out32++;
          end
        end
      end
      chk("in_ready64", in_ready64, !out_valid64 || out_ready64);
      if (in_valid64 && in_ready64) q64.push_back(model(64, a64, b64, cin64, sub64));
      if (out_valid64) begin
        if (q64.size() == 0) chk("out64_unexpected", out_valid64, 1'b0);
        else begin
          e = q64[0];
          chk("out64", out64, e.out);
          chk("cout64", cout64, e.cout);
          chk("ovf64", ovf64, e.ovf);
          chk("P64", p64, e.p);
          chk("G64", g64, e.g);
          if (out_ready64) begin
            void'(q64.pop_front());
            n_out64++;
          end
        end
      end
    end
  end

  task automatic set_op(input int i);
    in1 = 32'h1357_9BDF + 32'h1111_1111 * i;
    in2 = 32'hFEDC_BA98 ^ (32'h0101_0101 << (i % 24));
    cin = i[0];
    sub = i[1];
  endtask

  task automatic lit(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic s, input logic [31:0] eo,
                     input logic ec, input logic eov, input logic ep, input logic eg);
    int lat;
    @(posedge clk); #1;
    in1 = a; in2 = b; cin = ci; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 4);
    chk({name, "_out"}, out, eo);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, ovf, eov);
    chk({name, "_P"}, p_o, ep);
    chk({name, "_G"}, g_o, eg);
  endtask

  task automatic stream8();
    int cnt = 0, first = -1, last = -1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          set_op(i);
          in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (out_valid) begin
            cnt++;
            if (first < 0) first = c;
            last = c;
          end
        end
      end
    join
    chk("stream_count", cnt, 8);
    chk("stream_span", last - first, 7);
  endtask

  task automatic stall_test();
    int idx = 0, n0;
    bit acc;
    n0 = n_out32;
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_op(16);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; set_op(16 + idx); end
    end
    chk("stall_accepts", idx, 4);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; if (idx < 8) set_op(16 + idx); end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && (n_out32 - n0) < 8; c++) @(negedge clk);
    chk("stall_results", n_out32 - n0, 8);
  endtask

  task automatic reset_test();
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_op(30 + i);
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_reset_out_valid", out_valid, 1'b0);
    chk("mid_reset_out", out, 32'd0);
    chk("mid_reset_cout", cout, 1'b0);
    chk("mid_reset_ovf", ovf, 1'b0);
    chk("mid_reset_P", p_o, 1'b0);
    chk("mid_reset_G", g_o, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_reset_stale_results", seen, 0);
  endtask

  task automatic rand64();
    int  n0;
    bit  acc;
    n0 = n_out64;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      a64   = {$urandom(), $urandom()};
      b64   = {$urandom(), $urandom()};
      cin64 = 1'($urandom_range(0, 1));
      sub64 = 1'($urandom_range(0, 1));
      if (i == 0) begin a64 = '1; b64 = '0; cin64 = 1'b1; sub64 = 1'b0; end
      if (i == 1) begin a64 = 64'h8000_0000_0000_0000; b64 = 64'd1; cin64 = 1'b0; sub64 = 1'b1; end
      in_valid64  = 1'b1;
      out_ready64 = 1'($urandom_range(0, 1));
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk); acc = in_ready64;
        if (!acc) begin
          @(posedge clk); #1;
          out_ready64 = 1'($urandom_range(0, 1));
        end
      end
    end
    @(posedge clk); #1;
    in_valid64  = 1'b0;
    out_ready64 = 1'b1;
    for (int t = 0; t < 100 && (n_out64 - n0) < 40; t++) @(negedge clk);
    chk("rand64_results", n_out64 - n0, 40);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out", out, 32'd0);
    chk("reset_flags", {cout, ovf, p_o, g_o}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);

    lit("add_carry16", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("add_ripple",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    lit("sub_minneg",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    lit("sub_borrow",  32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1);
    lit("add_maxpos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);

    stream8();
    stall_test();
    reset_test();
    rand64();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
